// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared types and GMII constants for the two-port transmit arbiter.
// One-hot FSM encodings, bit indices for decoding, and the output bundle.
package gmii_tx_arbiter_pkg;

  localparam int IX_IDLE = 0;
  localparam int IX_PRE  = 1;
  localparam int IX_SFD  = 2;
  localparam int IX_DATA = 3;
  localparam int IX_IPG  = 4;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_PRE  = 5'b00010,
    S_SFD  = 5'b00100,
    S_DATA = 5'b01000,
    S_IPG  = 5'b10000
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_t;

endpackage

// File: rtl/gmii_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes
// to the port that was not granted last.
module rr_arbiter2 (
  input  logic req_0,
  input  logic req_1,
  input  logic last_gnt,
  output logic win,
  output logic any
);

  always_comb begin
    any = req_0 | req_1;
    win = (req_0 & req_1) ? ~last_gnt : req_1;
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit path between two frame sources.
// Define TX_ARB_JABBER_EN to cut frames longer than MAX_FRAME_BYTES.
module gmii_tx_arbiter
  import gmii_tx_arbiter_pkg::*;
#(
  parameter int IPG_BYTES       = 12,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       last_0,
  input  logic       last_1,
  input  logic       err_0,
  input  logic       err_1,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       rd_0,
  output logic       rd_1,
  input  logic       transmitting,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       underrun
);

  // An illegal configuration keeps the transmitter silent.
  localparam bit CFG_OK =
    (IPG_BYTES >= 1) && (IPG_BYTES <= 255) &&
    (PREAMBLE_BYTES >= 1) && (PREAMBLE_BYTES <= 15) &&
    (MAX_FRAME_BYTES >= 1) && (MAX_FRAME_BYTES <= 65535);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IPG_LOAD = 8'(IPG_BYTES - 1);
  localparam state_t FIRST_ST =
    (PREAMBLE_BYTES == 1) ? S_SFD : S_PRE;

  state_t      state_q, state_d;
  gmii_t       tx_q, tx_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        unr_q, unr_d;
  logic        lg_q, lg_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ipg_q, ipg_d;
  logic        win, any, start, abort, jab;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_err;

`ifdef TX_ARB_JABBER_EN
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
  logic jab_q, jab_d;
  assign jab = jab_q;
`else
  assign jab = 1'b0;
`endif

  rr_arbiter2 u_rr (
    .req_0    (req_0),
    .req_1    (req_1),
    .last_gnt (lg_q),
    .win      (win),
    .any      (any)
  );

  assign start   = any & ~transmitting & CFG_OK;
  assign s_data  = gnt1_q ? data_1  : data_0;
  assign s_valid = gnt1_q ? valid_1 : valid_0;
  assign s_last  = gnt1_q ? last_1  : last_0;
  assign s_err   = gnt1_q ? err_1   : err_0;
  assign abort   = jab | ~s_valid;

  assign rd_0 = gnt0_q & state_q[IX_DATA] & ~jab;
  assign rd_1 = gnt1_q & state_q[IX_DATA] & ~jab;

  assign gnt_0    = gnt0_q;
  assign gnt_1    = gnt1_q;
  assign TXD      = tx_q.txd;
  assign TX_EN    = tx_q.en;
  assign TX_ER    = tx_q.er;
  assign underrun = unr_q;

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      state_q <= S_IDLE;
      tx_q    <= '{IDLE_BYTE, 1'b0, 1'b0};
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      unr_q   <= 1'b0;
      lg_q    <= 1'b1;
      cnt_q   <= '0;
      ipg_q   <= '0;
`ifdef TX_ARB_JABBER_EN
      jab_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      unr_q   <= unr_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
      ipg_q   <= ipg_d;
`ifdef TX_ARB_JABBER_EN
      jab_q   <= jab_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[IX_IDLE]: if (start) state_d = FIRST_ST;
      state_q[IX_PRE]:  if (cnt_q == PRE_LAST) state_d = S_SFD;
      state_q[IX_SFD]:  state_d = S_DATA;
      state_q[IX_DATA]: if (abort || s_last) state_d = S_IPG;
      state_q[IX_IPG]:  if (ipg_q == 8'd0) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Outputs are loaded one edge ahead, so each byte lines up with its state.
  always_comb begin
    tx_d   = '{IDLE_BYTE, 1'b0, 1'b0};
    gnt0_d = gnt0_q;
    gnt1_d = gnt1_q;
    unr_d  = 1'b0;
    lg_d   = lg_q;
    cnt_d  = cnt_q;
    ipg_d  = ipg_q;
`ifdef TX_ARB_JABBER_EN
    jab_d  = jab_q;
`endif
    unique case (1'b1)
      state_q[IX_IDLE]: if (start) begin
        tx_d   = '{PREAMBLE_BYTE, 1'b1, 1'b0};
        gnt0_d = ~win;
        gnt1_d = win;
        lg_d   = win;
        cnt_d  = 16'd1;
      end
      state_q[IX_PRE]: begin
        tx_d  = '{PREAMBLE_BYTE, 1'b1, 1'b0};
        cnt_d = cnt_q + 16'd1;
      end
      state_q[IX_SFD]: begin
        tx_d  = '{SFD_BYTE, 1'b1, 1'b0};
        cnt_d = '0;
      end
      state_q[IX_DATA]: if (abort) begin
        tx_d   = '{IDLE_BYTE, 1'b1, 1'b1};
        unr_d  = 1'b1;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        ipg_d  = IPG_LOAD;
`ifdef TX_ARB_JABBER_EN
        jab_d  = 1'b0;
`endif
      end else begin
        tx_d = '{s_data, 1'b1, s_err};
`ifdef TX_ARB_JABBER_EN
        cnt_d = cnt_q + 16'd1;
        if (!s_last && cnt_d == MAX_LEN) jab_d = 1'b1;
`endif
        if (s_last) begin
          gnt0_d = 1'b0;
          gnt1_d = 1'b0;
          ipg_d  = IPG_LOAD;
        end
      end
      state_q[IX_IPG]: if (ipg_q != 8'd0) ipg_d = ipg_q - 8'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter with default IPG and preamble
// lengths; jabber expectations follow TX_ARB_JABBER_EN.
module tb_gmii_tx_arbiter;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset = 1'b0;
  logic       transmitting = 1'b0;
  logic       req_0, req_1, valid_0, valid_1;
  logic       last_0, last_1, err_0, err_1;
  logic [7:0] data_0, data_1;
  logic       gnt_0, gnt_1, rd_0, rd_1;
  logic [7:0] TXD;
  logic       TX_EN, TX_ER, underrun;

  logic        en0 = 1'b0, en1 = 1'b0;
  int          len0 = 0, len1 = 0;
  int          idx0 = 0, idx1 = 0;
  int          drop0 = -1, drop1 = -1;
  logic [7:0]  f0 [16];
  logic [7:0]  f1 [16];
  logic [15:0] emask0 = '0, emask1 = '0;

  int checks = 0;
  int failures = 0;

  always #5 GTX_CLK = ~GTX_CLK;

  gmii_tx_arbiter #(
    .IPG_BYTES       (12),
    .PREAMBLE_BYTES  (7),
    .MAX_FRAME_BYTES (8)
  ) dut (
    .GTX_CLK       (GTX_CLK),
    .mr_main_reset (mr_main_reset),
    .req_0         (req_0),
    .req_1         (req_1),
    .data_0        (data_0),
    .data_1        (data_1),
    .valid_0       (valid_0),
    .valid_1       (valid_1),
    .last_0        (last_0),
    .last_1        (last_1),
    .err_0         (err_0),
    .err_1         (err_1),
    .gnt_0         (gnt_0),
    .gnt_1         (gnt_1),
    .rd_0          (rd_0),
    .rd_1          (rd_1),
    .transmitting  (transmitting),
    .TXD           (TXD),
    .TX_EN         (TX_EN),
    .TX_ER         (TX_ER),
    .underrun      (underrun)
  );

  // Frame sources: advance on each accepted byte, rewind when disabled.
  assign req_0   = en0 && (idx0 < len0);
  assign valid_0 = req_0 && (idx0 != drop0);
  assign data_0  = f0[idx0[3:0]];
  assign last_0  = (idx0 == len0 - 1);
  assign err_0   = emask0[idx0[3:0]];

  assign req_1   = en1 && (idx1 < len1);
  assign valid_1 = req_1 && (idx1 != drop1);
  assign data_1  = f1[idx1[3:0]];
  assign last_1  = (idx1 == len1 - 1);
  assign err_1   = emask1[idx1[3:0]];

  always @(posedge GTX_CLK) begin
    if (!en0) idx0 <= 0;
    else if (rd_0 && valid_0) idx0 <= idx0 + 1;
    if (!en1) idx1 <= 0;
    else if (rd_1 && valid_1) idx1 <= idx1 + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge GTX_CLK);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [7:0] txd,
                          input logic en, input logic er);
    tick();
    chk(tag, 32'({TX_ER, TX_EN, TXD}), 32'({er, en, txd}));
  endtask

  task automatic load(input bit p, input int n,
                      input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 16; i++) begin
      if (p) f1[i] = base + 8'(i) * step;
      else   f0[i] = base + 8'(i) * step;
    end
    if (p) len1 = n;
    else   len0 = n;
  endtask

  task automatic expect_frame(input string tag, input bit p, input int n);
    for (int i = 0; i < 7; i++) begin
      tick_chk({tag, "_pre"}, 8'h55, 1'b1, 1'b0);
      if (i == 0)
        chk({tag, "_gnt"}, 32'({gnt_1, gnt_0}), p ? 32'd2 : 32'd1);
    end
    tick_chk({tag, "_sfd"}, 8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++)
      tick_chk({tag, "_data"}, p ? f1[i] : f0[i], 1'b1,
               p ? emask1[i] : emask0[i]);
  endtask

  task automatic expect_ipg(input string tag, input int n);
    for (int i = 0; i < n; i++) tick_chk(tag, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_tx", 32'({TX_ER, TX_EN, TXD}), 32'd0);
    chk("rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
    chk("rst_unr", 32'(underrun), 32'd0);
    mr_main_reset = 1'b1;
    expect_ipg("idle", 4);
    chk("idle_gnt", 32'({gnt_1, gnt_0}), 32'd0);

    load(1'b0, 4, 8'hAA, 8'h11);
    en0 = 1'b1;
    expect_frame("f0", 1'b0, 4);
    chk("f0_gnt_drop", 32'({gnt_1, gnt_0}), 32'd0);
    en0 = 1'b0;
    expect_ipg("f0_ipg", 12);
    tick_chk("f0_idle", 8'h00, 1'b0, 1'b0);

    mr_main_reset = 1'b0;
    tick();
    load(1'b0, 2, 8'h11, 8'h11);
    load(1'b1, 3, 8'h33, 8'h11);
    en0 = 1'b1;
    en1 = 1'b1;
    tick();
    mr_main_reset = 1'b1;
    expect_frame("tie_a", 1'b0, 2);
    chk("tie_a_end", 32'({gnt_1, gnt_0}), 32'd0);
    en0 = 1'b0;
    expect_ipg("tie_a_ipg", 12);
    expect_frame("tie_b", 1'b1, 3);
    chk("tie_b_end", 32'({gnt_1, gnt_0}), 32'd0);
    en1 = 1'b0;
    expect_ipg("tie_b_ipg", 1);
    load(1'b0, 1, 8'h66, 8'h00);
    load(1'b1, 1, 8'h77, 8'h00);
    en0 = 1'b1;
    en1 = 1'b1;
    expect_ipg("tie_b_ipg", 11);
    expect_frame("tie_c", 1'b0, 1);
    en0 = 1'b0;
    expect_ipg("tie_c_ipg", 12);
    expect_frame("tie_d", 1'b1, 1);
    en1 = 1'b0;
    expect_ipg("tie_d_ipg", 12);

    load(1'b1, 5, 8'hA0, 8'h01);
    drop1 = 2;
    en1 = 1'b1;
    expect_frame("unr", 1'b1, 2);
    chk("unr_quiet", 32'(underrun), 32'd0);
    tick_chk("unr_err", 8'h00, 1'b1, 1'b1);
    chk("unr_pulse", 32'(underrun), 32'd1);
    chk("unr_gnt", 32'({gnt_1, gnt_0}), 32'd0);
    en1 = 1'b0;
    drop1 = -1;
    tick_chk("unr_ipg", 8'h00, 1'b0, 1'b0);
    chk("unr_pulse_end", 32'(underrun), 32'd0);
    expect_ipg("unr_ipg", 11);

    transmitting = 1'b1;
    load(1'b0, 4, 8'hC0, 8'h01);
    emask0 = 16'h0002;
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_chk("busy_hold", 8'h00, 1'b0, 1'b0);
      chk("busy_gnt", 32'({gnt_1, gnt_0}), 32'd0);
    end
    transmitting = 1'b0;
    expect_frame("busy_f", 1'b0, 4);
    en0 = 1'b0;
    emask0 = '0;
    expect_ipg("busy_ipg", 12);

    load(1'b0, 10, 8'h01, 8'h01);
    en0 = 1'b1;
`ifdef TX_ARB_JABBER_EN
    expect_frame("jab", 1'b0, 8);
    chk("jab_own", 32'({gnt_1, gnt_0}), 32'd1);
    tick_chk("jab_err", 8'h00, 1'b1, 1'b1);
    chk("jab_unr", 32'(underrun), 32'd1);
    chk("jab_gnt", 32'({gnt_1, gnt_0}), 32'd0);
`else
    expect_frame("jab", 1'b0, 10);
    chk("jab_unr", 32'(underrun), 32'd0);
    chk("jab_gnt", 32'({gnt_1, gnt_0}), 32'd0);
`endif
    en0 = 1'b0;
    expect_ipg("jab_ipg", 12);

    load(1'b0, 3, 8'h5A, 8'h00);
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) tick_chk("mid_pre", 8'h55, 1'b1, 1'b0);
    mr_main_reset = 1'b0;
    tick();
    chk("mid_tx", 32'({TX_ER, TX_EN, TXD}), 32'd0);
    chk("mid_gnt", 32'({gnt_1, gnt_0}), 32'd0);
    chk("mid_unr", 32'(underrun), 32'd0);
    en0 = 1'b0;
    tick();
    mr_main_reset = 1'b1;
    expect_ipg("mid_idle", 3);
    chk("mid_idle_gnt", 32'({gnt_1, gnt_0}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
